// File: rtl/multicycle_control_unit_if.sv
// Instruction/memory side handshake and datapath control bundle
// for the multi-cycle control unit.
interface multicycle_control_unit_if #(
   parameter int OP_W     = 4,
   parameter int FUNCT_W  = 5,
   parameter int ALUCTL_W = 5,
   parameter int IMMSRC_W = 2
);
   logic                instr_valid;
   logic [OP_W-1:0]     op;
   logic [FUNCT_W-1:0]  funct;
   logic                mem_ready;
   logic                zero;

   logic                ir_write;
   logic                pc_write;
   logic [1:0]          pc_src;
   logic                reg_write;
   logic                alu_src;
   logic [IMMSRC_W-1:0] imm_src;
   logic [ALUCTL_W-1:0] alu_control;
   logic                mem_read;
   logic                mem_write;
   logic                result_src;
   logic                stack_push;
   logic                stack_pop;
   logic                busy;
   logic                halted;
   logic                illegal_op;

   modport master (
      input  instr_valid, op, funct, mem_ready, zero,
      output ir_write, pc_write, pc_src, reg_write,
      output alu_src, imm_src, alu_control,
      output mem_read, mem_write, result_src,
      output stack_push, stack_pop,
      output busy, halted, illegal_op
   );

   modport slave (
      output instr_valid, op, funct, mem_ready, zero,
      input  ir_write, pc_write, pc_src, reg_write,
      input  alu_src, imm_src, alu_control,
      input  mem_read, mem_write, result_src,
      input  stack_push, stack_pop,
      input  busy, halted, illegal_op
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 19-bit CPU: FETCH/DECODE/EXEC/MEM/WB/HALT
// sequencing over a shared ALU and a single memory port.
module multicycle_control_unit #(
   parameter int OP_W     = 4,
   parameter int FUNCT_W  = 5,
   parameter int ALUCTL_W = 5,
   parameter int IMMSRC_W = 2
) (
   input  logic clk,
   input  logic rst,
   multicycle_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   localparam logic [OP_W-1:0] OP_RALU  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_IALU  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_CALL  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_RET   = OP_W'(7);
   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

   localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
   localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);

   localparam logic [IMMSRC_W-1:0] IMM_I = IMMSRC_W'(0);
   localparam logic [IMMSRC_W-1:0] IMM_M = IMMSRC_W'(1);
   localparam logic [IMMSRC_W-1:0] IMM_B = IMMSRC_W'(2);
   localparam logic [IMMSRC_W-1:0] IMM_J = IMMSRC_W'(3);

   localparam logic [1:0] PC_INC = 2'b00;
   localparam logic [1:0] PC_TGT = 2'b01;
   localparam logic [1:0] PC_STK = 2'b10;

   state_e               state_q, state_d;
   logic [OP_W-1:0]      op_q, op_d;
   logic [FUNCT_W-1:0]   funct_q, funct_d;
   logic [ALUCTL_W-1:0]  funct_ext;

   logic                 ir_write;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 reg_write;
   logic                 alu_src;
   logic [IMMSRC_W-1:0]  imm_src;
   logic [ALUCTL_W-1:0]  alu_control;
   logic                 mem_read;
   logic                 mem_write;
   logic                 result_src;
   logic                 stack_push;
   logic                 stack_pop;
   logic                 illegal_op;

   logic is_ralu, is_ialu, is_load, is_store, is_mem;
   logic is_beq, is_jump, is_call, is_ret, is_halt, is_exec;

   // funct feeds alu_control directly, so fit it to the ALU control width
   if (ALUCTL_W > FUNCT_W) begin : g_fext
      assign funct_ext = {{(ALUCTL_W-FUNCT_W){1'b0}}, funct_q};
   end else if (ALUCTL_W == FUNCT_W) begin : g_feq
      assign funct_ext = funct_q;
   end else begin : g_ftrunc
      assign funct_ext = funct_q[ALUCTL_W-1:0];
   end

   assign is_ralu  = (op_q == OP_RALU);
   assign is_ialu  = (op_q == OP_IALU);
   assign is_load  = (op_q == OP_LOAD);
   assign is_store = (op_q == OP_STORE);
   assign is_beq   = (op_q == OP_BEQ);
   assign is_jump  = (op_q == OP_JUMP);
   assign is_call  = (op_q == OP_CALL);
   assign is_ret   = (op_q == OP_RET);
   assign is_halt  = (op_q == OP_HALT);
   assign is_mem   = is_load | is_store;
   assign is_exec  = is_ralu | is_ialu | is_mem | is_beq |
                     is_jump | is_call | is_ret;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      funct_d     = funct_q;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_INC;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      imm_src     = IMM_I;
      alu_control = ALU_ADD;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      result_src  = 1'b0;
      stack_push  = 1'b0;
      stack_pop   = 1'b0;
      illegal_op  = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            if (bus.instr_valid) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               op_d     = bus.op;
               funct_d  = bus.funct;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               is_halt: state_d = S_HALT;
               is_exec: state_d = S_EXEC;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            unique case (1'b1)
               is_ralu: begin
                  alu_control = funct_ext;
                  state_d     = S_WB;
               end
               is_ialu: begin
                  alu_src     = 1'b1;
                  alu_control = funct_ext;
                  state_d     = S_WB;
               end
               is_mem: begin
                  alu_src = 1'b1;
                  imm_src = IMM_M;
                  state_d = S_MEM;
               end
               is_beq: begin
                  alu_control = ALU_SUB;
                  imm_src     = IMM_B;
                  if (bus.zero) begin
                     pc_write = 1'b1;
                     pc_src   = PC_TGT;
                  end
               end
               is_jump, is_call: begin
                  imm_src    = IMM_J;
                  pc_write   = 1'b1;
                  pc_src     = PC_TGT;
                  stack_push = is_call;
               end
               is_ret: begin
                  pc_write  = 1'b1;
                  pc_src    = PC_STK;
                  stack_pop = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            // address path held steady for the whole wait
            alu_src   = 1'b1;
            imm_src   = IMM_M;
            mem_read  = is_load;
            mem_write = is_store;
            if (bus.mem_ready) begin
               state_d = is_load ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            result_src = is_load;
            state_d    = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // reset cycle squashes every output, including a pending MEM strobe
   assign bus.ir_write    = rst & ir_write;
   assign bus.pc_write    = rst & pc_write;
   assign bus.pc_src      = rst ? pc_src : 2'b00;
   assign bus.reg_write   = rst & reg_write;
   assign bus.alu_src     = rst & alu_src;
   assign bus.imm_src     = rst ? imm_src : '0;
   assign bus.alu_control = rst ? alu_control : '0;
   assign bus.mem_read    = rst & mem_read;
   assign bus.mem_write   = rst & mem_write;
   assign bus.result_src  = rst & result_src;
   assign bus.stack_push  = rst & stack_push;
   assign bus.stack_pop   = rst & stack_pop;
   assign bus.busy        = rst & (state_q != S_FETCH);
   assign bus.halted      = rst & (state_q == S_HALT);
   assign bus.illegal_op  = rst & illegal_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle output vectors
// against hand-computed expectations.
module tb_multicycle_control_unit;

   logic clk;
   logic rst;

   multicycle_control_unit_if #(
      .OP_W(4), .FUNCT_W(5), .ALUCTL_W(5), .IMMSRC_W(2)
   ) bus ();

   multicycle_control_unit #(
      .OP_W(4), .FUNCT_W(5), .ALUCTL_W(5), .IMMSRC_W(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          r;
      int          iv;
      int          op;
      int          fn;
      int          mr;
      int          z;
      logic [20:0] exp;
   } vec_t;

   int checks = 0;
   int errors = 0;

   logic [20:0] IDL, FET, BSY, HLT;

   function automatic logic [20:0] ev(
      input int ir, input int pcw, input int pcs, input int rw,
      input int as, input int is, input int ac, input int mr,
      input int mw, input int rs, input int sp, input int pp,
      input int bz, input int hl, input int il
   );
      return {ir[0], pcw[0], pcs[1:0], rw[0], as[0], is[1:0],
              ac[4:0], mr[0], mw[0], rs[0], sp[0], pp[0],
              bz[0], hl[0], il[0]};
   endfunction

   function automatic logic [20:0] obs();
      return {bus.ir_write, bus.pc_write, bus.pc_src,
              bus.reg_write, bus.alu_src, bus.imm_src,
              bus.alu_control, bus.mem_read, bus.mem_write,
              bus.result_src, bus.stack_push, bus.stack_pop,
              bus.busy, bus.halted, bus.illegal_op};
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst             = v.r[0];
      bus.instr_valid = v.iv[0];
      bus.op          = v.op[3:0];
      bus.funct       = v.fn[4:0];
      bus.mem_ready   = v.mr[0];
      bus.zero        = v.z[0];
      #1;
   endtask

   task automatic test_reset();
      vec_t v[$];
      logic [20:0] got;
      v.push_back('{0, 0, 0, 0, 0, 0, IDL});
      v.push_back('{0, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 1, 3, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,1,1,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,1,1,0,0,1,0,0,0,1,0,0)});
      v.push_back('{0, 0, 0, 0, 0, 0, IDL});
      v.push_back('{0, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 0, 0, 0, 1, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL reset cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_alu();
      vec_t v[$];
      logic [20:0] got;
      v.push_back('{1, 1, 0, 3, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,0,0,3,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,1,0,0,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 1, 1, 10, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,1,0,10,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,1,0,0,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL alu cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_load_wait();
      vec_t v[$];
      logic [20:0] got;
      logic [20:0] mrd;
      mrd = ev(0,0,0,0,1,1,0,1,0,0,0,0,1,0,0);
      v.push_back('{1, 1, 2, 31, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 1, 0, BSY});
      v.push_back('{1, 0, 0, 0, 1, 0,
         ev(0,0,0,0,1,1,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, mrd});
      v.push_back('{1, 0, 0, 0, 0, 0, mrd});
      v.push_back('{1, 0, 0, 0, 0, 0, mrd});
      v.push_back('{1, 0, 0, 0, 1, 0, mrd});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,1,0,0,0,0,0,1,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL load cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_beq();
      vec_t v[$];
      logic [20:0] got;
      v.push_back('{1, 1, 4, 0, 0, 1, FET});
      v.push_back('{1, 1, 0, 0, 0, 1, BSY});
      v.push_back('{1, 0, 0, 0, 0, 1,
         ev(0,1,1,0,0,2,1,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 1, 4, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 1, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,0,2,1,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL beq cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[$];
      logic [20:0] got;
      v.push_back('{1, 1, 6, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,1,1,0,0,3,0,0,0,0,1,0,1,0,0)});
      v.push_back('{1, 1, 7, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,1,2,0,0,0,0,0,0,0,0,1,1,0,0)});
      v.push_back('{1, 1, 5, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,1,1,0,0,3,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL call_ret cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
         checks++;
         if (bus.stack_push === 1'b1 && bus.stack_pop === 1'b1) begin
            errors++;
            $display("FAIL push_pop cyc %0d: got both 1 expected not both",
                     i);
         end
      end
   endtask

   task automatic test_illegal_halt();
      vec_t v[$];
      logic [20:0] got;
      v.push_back('{1, 1, 9, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,0,0,0,0,0,0,0,0,0,0,0,1,0,1)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 1, 15, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 1, 0, 3, 0, 0, HLT});
      v.push_back('{1, 1, 2, 0, 1, 1, HLT});
      v.push_back('{1, 0, 0, 0, 0, 0, HLT});
      v.push_back('{0, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      v.push_back('{1, 1, 5, 0, 0, 0, FET});
      v.push_back('{1, 0, 0, 0, 0, 0, BSY});
      v.push_back('{1, 0, 0, 0, 0, 0,
         ev(0,1,1,0,0,3,0,0,0,0,0,0,1,0,0)});
      v.push_back('{1, 0, 0, 0, 0, 0, IDL});
      foreach (v[i]) begin
         apply(v[i]);
         got = obs();
         checks++;
         if (got !== v[i].exp) begin
            errors++;
            $display("FAIL illegal_halt cyc %0d: got %h expected %h",
                     i, got, v[i].exp);
         end
      end
   endtask

   initial begin
      rst             = 1'b0;
      bus.instr_valid = 1'b0;
      bus.op          = '0;
      bus.funct       = '0;
      bus.mem_ready   = 1'b0;
      bus.zero        = 1'b0;
      IDL = '0;
      FET = ev(1,1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      BSY = ev(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0);
      HLT = ev(0,0,0,0,0,0,0,0,0,0,0,0,1,1,0);
      test_reset();
      test_alu();
      test_load_wait();
      test_beq();
      test_back_to_back();
      test_illegal_halt();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
